// File: rtl/lpif_txrx_x1_asym1_half_slave_gearbox_if.sv
// lpif_txrx_x1_asym1_half_slave_gearbox_if: rx/tx FIFO word and single-beat handshake bundle
interface lpif_txrx_x1_asym1_half_slave_gearbox_if #(parameter int DWIDTH = 32);
  localparam int BW = DWIDTH + 10;
  logic [2*BW-1:0] rxfifo_upstream_data;
  logic rxfifo_upstream_vld;
  logic rxfifo_upstream_rdy;
  logic [3:0] ustrm_state;
  logic [1:0] ustrm_protid;
  logic [DWIDTH-1:0] ustrm_data;
  logic ustrm_dvalid;
  logic ustrm_crc;
  logic ustrm_crc_valid;
  logic ustrm_valid;
  logic ustrm_beat_vld;
  logic ustrm_beat_rdy;
  logic [3:0] dstrm_state;
  logic [1:0] dstrm_protid;
  logic [DWIDTH-1:0] dstrm_data;
  logic dstrm_dvalid;
  logic dstrm_crc;
  logic dstrm_crc_valid;
  logic dstrm_valid;
  logic dstrm_beat_vld;
  logic dstrm_beat_rdy;
  logic [2*BW-1:0] txfifo_downstream_data;
  logic txfifo_downstream_vld;
  logic txfifo_downstream_rdy;
  modport slave (
    input rxfifo_upstream_data, rxfifo_upstream_vld, ustrm_beat_rdy,
    input dstrm_state, dstrm_protid, dstrm_data, dstrm_dvalid, dstrm_crc, dstrm_crc_valid, dstrm_valid,
    input dstrm_beat_vld, txfifo_downstream_rdy,
    output rxfifo_upstream_rdy, ustrm_state, ustrm_protid, ustrm_data, ustrm_dvalid, ustrm_crc,
    output ustrm_crc_valid, ustrm_valid, ustrm_beat_vld, dstrm_beat_rdy,
    output txfifo_downstream_data, txfifo_downstream_vld
  );
  modport master (
    output rxfifo_upstream_data, rxfifo_upstream_vld, ustrm_beat_rdy,
    output dstrm_state, dstrm_protid, dstrm_data, dstrm_dvalid, dstrm_crc, dstrm_crc_valid, dstrm_valid,
    output dstrm_beat_vld, txfifo_downstream_rdy,
    input rxfifo_upstream_rdy, ustrm_state, ustrm_protid, ustrm_data, ustrm_dvalid, ustrm_crc,
    input ustrm_crc_valid, ustrm_valid, ustrm_beat_vld, dstrm_beat_rdy,
    input txfifo_downstream_data, txfifo_downstream_vld
  );
endinterface

// File: rtl/lpif_txrx_x1_asym1_half_slave_gearbox.sv
// lpif_txrx_x1_asym1_half_slave_gearbox: unpacks 2-beat words upstream, packs beat pairs downstream
// Optional LPIF_GEARBOX_PAD_EN: zero-pads a lone low half after PAD_TIMEOUT idle cycles.
module lpif_txrx_x1_asym1_half_slave_gearbox #(
  parameter int DWIDTH = 32,
  parameter int PAD_TIMEOUT = 16
) (
  input logic clk_wr,
  input logic rst_wr,
  lpif_txrx_x1_asym1_half_slave_gearbox_if.slave g
);
  localparam int BW = DWIDTH + 10;
  typedef enum logic [1:0] {EMPTY, B0, B1} st_t;
  st_t st_q, st_d;
  logic [2*BW-1:0] word_q, wd_q;
  logic [BW-1:0] beat, din, lo_q;
  logic up_acc, dn_acc, form, pad, lo_vld_q, wd_vld_q;
  assign g.rxfifo_upstream_rdy = (st_q == EMPTY) | (st_q == B1 & g.ustrm_beat_rdy);
  assign up_acc = g.rxfifo_upstream_vld & g.rxfifo_upstream_rdy;
  assign g.ustrm_beat_vld = st_q != EMPTY;
  always_comb begin
    st_d = up_acc ? B0 : (st_q == B0 & g.ustrm_beat_rdy) ? B1 : (st_q == B1 & g.ustrm_beat_rdy) ? EMPTY : st_q;
    beat = st_q == B0 ? word_q[BW-1:0] : st_q == B1 ? word_q[2*BW-1:BW] : '0;
  end
  assign {g.ustrm_valid, g.ustrm_crc_valid, g.ustrm_crc, g.ustrm_dvalid, g.ustrm_data, g.ustrm_protid, g.ustrm_state} = beat;
  assign din = {g.dstrm_valid, g.dstrm_crc_valid, g.dstrm_crc, g.dstrm_dvalid, g.dstrm_data, g.dstrm_protid, g.dstrm_state};
  // a new low half may be captured while a finished word is still waiting
  assign g.dstrm_beat_rdy = !(lo_vld_q & wd_vld_q & !g.txfifo_downstream_rdy);
  assign dn_acc = g.dstrm_beat_vld & g.dstrm_beat_rdy;
  assign form = dn_acc & lo_vld_q;
  assign g.txfifo_downstream_data = wd_q;
  assign g.txfifo_downstream_vld = wd_vld_q;
`ifdef LPIF_GEARBOX_PAD_EN
  logic [7:0] cnt_q, cnt_inc;
  assign cnt_inc = cnt_q == 8'(PAD_TIMEOUT) ? cnt_q : cnt_q + 8'd1;
  assign pad = lo_vld_q & !dn_acc & cnt_inc == 8'(PAD_TIMEOUT) & (!wd_vld_q | g.txfifo_downstream_rdy);
  always_ff @(posedge clk_wr)
    cnt_q <= (rst_wr | !lo_vld_q | dn_acc) ? 8'd0 : cnt_inc;
`else
  // padding compiled out; the comparison is constant-false over the legal PAD_TIMEOUT range
  assign pad = PAD_TIMEOUT < 0;
`endif
  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      st_q <= EMPTY;
      word_q <= '0;
      lo_q <= '0;
      lo_vld_q <= 1'b0;
      wd_q <= '0;
      wd_vld_q <= 1'b0;
    end else begin
      st_q <= st_d;
      if (up_acc) word_q <= g.rxfifo_upstream_data;
      if (dn_acc & !lo_vld_q) lo_q <= din;
      lo_vld_q <= (dn_acc & !lo_vld_q) | (lo_vld_q & !form & !pad);
      if (form) wd_q <= {din, lo_q};
      else if (pad) wd_q <= {{BW{1'b0}}, lo_q};
      wd_vld_q <= form | pad | (wd_vld_q & !g.txfifo_downstream_rdy);
    end
  end
endmodule

// File: tb/tb_lpif_txrx_x1_asym1_half_slave_gearbox.sv
// tb_lpif_txrx_x1_asym1_half_slave_gearbox: directed checks of unpack, pack, backpressure, reset and padding
module tb_lpif_txrx_x1_asym1_half_slave_gearbox;
  logic clk_wr = 1'b0;
  logic rst_wr = 1'b1;
  always #5 clk_wr = ~clk_wr;
  lpif_txrx_x1_asym1_half_slave_gearbox_if #(.DWIDTH(32)) g();
  lpif_txrx_x1_asym1_half_slave_gearbox #(.DWIDTH(32), .PAD_TIMEOUT(4)) dut (.clk_wr(clk_wr), .rst_wr(rst_wr), .g(g));
  int n_cmp = 0;
  int n_bad = 0;
  logic [41:0] ubeat;
  assign ubeat = {g.ustrm_valid, g.ustrm_crc_valid, g.ustrm_crc, g.ustrm_dvalid, g.ustrm_data, g.ustrm_protid, g.ustrm_state};
  function automatic logic [41:0] mk(input logic [3:0] s, input logic [1:0] p, input logic [31:0] d,
                                     input logic dv, input logic c, input logic cv, input logic v);
    return {v, cv, c, dv, d, p, s};
  endfunction
  function automatic logic [83:0] wd(input int k);
    return {mk(4'd0, 2'd0, 32'(2*k+1), 1'b0, 1'b0, 1'b0, 1'b0), mk(4'd0, 2'd0, 32'(2*k), 1'b0, 1'b0, 1'b0, 1'b0)};
  endfunction
  function automatic logic [41:0] bt(input int k);
    return mk(4'd0, 2'd0, 32'h100 + 32'(k), 1'b0, 1'b0, 1'b0, 1'b1);
  endfunction
  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic sb(input logic v, input logic [41:0] b);
    g.dstrm_beat_vld = v;
    {g.dstrm_valid, g.dstrm_crc_valid, g.dstrm_crc, g.dstrm_dvalid, g.dstrm_data, g.dstrm_protid, g.dstrm_state} = b;
  endtask
  task automatic step;
    @(posedge clk_wr);
    #2;
  endtask
  initial begin
    logic [83:0] tw;
    logic [41:0] ba, bb;
    logic a;
    int k, nw, seen;
    g.rxfifo_upstream_vld = 1'b0;
    g.rxfifo_upstream_data = '0;
    g.ustrm_beat_rdy = 1'b0;
    g.txfifo_downstream_rdy = 1'b0;
    sb(1'b0, '0);
    step;
    step;
    #1;
    chk("rst_up_rdy", g.rxfifo_upstream_rdy, 1);
    chk("rst_beat_vld", g.ustrm_beat_vld, 0);
    chk("rst_ubeat", ubeat, 0);
    chk("rst_dn_rdy", g.dstrm_beat_rdy, 1);
    chk("rst_tx_vld", g.txfifo_downstream_vld, 0);
    chk("rst_tx_data", g.txfifo_downstream_data, 0);
    rst_wr = 1'b0;
    // single upstream word, all fields distinct per slice
    tw = {mk(4'd9, 2'd2, 32'h22222222, 1'b1, 1'b0, 1'b1, 1'b1), mk(4'd5, 2'd1, 32'h11111111, 1'b0, 1'b1, 1'b0, 1'b1)};
    g.rxfifo_upstream_data = tw;
    g.rxfifo_upstream_vld = 1'b1;
    g.ustrm_beat_rdy = 1'b1;
    #1;
    chk("up_rdy_empty", g.rxfifo_upstream_rdy, 1);
    step;
    g.rxfifo_upstream_vld = 1'b0;
    #1;
    chk("b0_vld", g.ustrm_beat_vld, 1);
    chk("b0_data", g.ustrm_data, 32'h11111111);
    chk("b0_state", g.ustrm_state, 4'd5);
    chk("b0_protid", g.ustrm_protid, 2'd1);
    chk("b0_beat", ubeat, mk(4'd5, 2'd1, 32'h11111111, 1'b0, 1'b1, 1'b0, 1'b1));
    chk("b0_up_rdy", g.rxfifo_upstream_rdy, 0);
    step;
    #1;
    chk("b1_vld", g.ustrm_beat_vld, 1);
    chk("b1_data", g.ustrm_data, 32'h22222222);
    chk("b1_beat", ubeat, mk(4'd9, 2'd2, 32'h22222222, 1'b1, 1'b0, 1'b1, 1'b1));
    chk("b1_up_rdy", g.rxfifo_upstream_rdy, 1);
    step;
    #1;
    chk("empty_vld", g.ustrm_beat_vld, 0);
    // eight back-to-back words, one beat per cycle
    k = 0;
    g.rxfifo_upstream_data = wd(0);
    g.rxfifo_upstream_vld = 1'b1;
    for (int c = 0; c < 16; c++) begin
      #1;
      chk($sformatf("b2b_rdy%0d", c), g.rxfifo_upstream_rdy, (c % 2) == 0);
      step;
      if (c % 2 == 0) begin
        k++;
        if (k < 8) g.rxfifo_upstream_data = wd(k);
        else g.rxfifo_upstream_vld = 1'b0;
      end
      #1;
      chk($sformatf("b2b_vld%0d", c), g.ustrm_beat_vld, 1);
      chk($sformatf("b2b_data%0d", c), g.ustrm_data, 32'(c));
    end
    step;
    #1;
    chk("b2b_end_vld", g.ustrm_beat_vld, 0);
    // downstream pair A then B
    ba = mk(4'd3, 2'd0, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, 1'b1);
    bb = mk(4'd9, 2'd0, 32'h5A5A5A5A, 1'b0, 1'b0, 1'b0, 1'b1);
    g.txfifo_downstream_rdy = 1'b1;
    sb(1'b1, ba);
    #1;
    chk("dn_rdy", g.dstrm_beat_rdy, 1);
    step;
    sb(1'b1, bb);
    #1;
    chk("dn_half_vld", g.txfifo_downstream_vld, 0);
    step;
    sb(1'b0, '0);
    #1;
    chk("pk_vld", g.txfifo_downstream_vld, 1);
    chk("pk_a_data", g.txfifo_downstream_data[37:6], 32'hA5A5A5A5);
    chk("pk_a_state", g.txfifo_downstream_data[3:0], 4'd3);
    chk("pk_b_data", g.txfifo_downstream_data[79:48], 32'h5A5A5A5A);
    chk("pk_b_state", g.txfifo_downstream_data[45:42], 4'd9);
    chk("pk_word", g.txfifo_downstream_data, {bb, ba});
    step;
    #1;
    chk("pk_drained", g.txfifo_downstream_vld, 0);
    // tx backpressure for 10 cycles under continuous beats
    g.txfifo_downstream_rdy = 1'b0;
    k = 0;
    sb(1'b1, bt(0));
    for (int i = 0; i < 10; i++) begin
      #1;
      a = g.dstrm_beat_rdy;
      step;
      if (a) begin
        k++;
        sb(1'b1, bt(k));
      end
    end
    #1;
    chk("bp_accepted", k, 3);
    chk("bp_rdy_low", g.dstrm_beat_rdy, 0);
    chk("bp_tx_vld", g.txfifo_downstream_vld, 1);
    chk("bp_tx_hold", g.txfifo_downstream_data, {bt(1), bt(0)});
    g.txfifo_downstream_rdy = 1'b1;
    nw = 0;
    for (int i = 0; i < 30 && nw < 3; i++) begin
      #1;
      if (g.txfifo_downstream_vld) begin
        chk($sformatf("bp_word%0d", nw), g.txfifo_downstream_data, {bt(2*nw+1), bt(2*nw)});
        nw++;
      end
      a = g.dstrm_beat_rdy & g.dstrm_beat_vld;
      step;
      if (a) begin
        k++;
        if (k < 6) sb(1'b1, bt(k));
        else sb(1'b0, '0);
      end
    end
    chk("bp_words", nw, 3);
    chk("bp_beats", k, 6);
    #1;
    chk("bp_empty", g.txfifo_downstream_vld, 0);
    // reset while unpack sits in B0 and a low half is held
    g.rxfifo_upstream_data = wd(5);
    g.rxfifo_upstream_vld = 1'b1;
    g.ustrm_beat_rdy = 1'b0;
    sb(1'b1, bt(9));
    step;
    g.rxfifo_upstream_vld = 1'b0;
    sb(1'b0, '0);
    #1;
    chk("pre_rst_b0", g.ustrm_beat_vld, 1);
    rst_wr = 1'b1;
    step;
    rst_wr = 1'b0;
    #1;
    chk("mrst_beat_vld", g.ustrm_beat_vld, 0);
    chk("mrst_tx_vld", g.txfifo_downstream_vld, 0);
    chk("mrst_up_rdy", g.rxfifo_upstream_rdy, 1);
    chk("mrst_dn_rdy", g.dstrm_beat_rdy, 1);
    g.ustrm_beat_rdy = 1'b1;
    g.rxfifo_upstream_data = wd(6);
    g.rxfifo_upstream_vld = 1'b1;
    sb(1'b1, bt(20));
    step;
    g.rxfifo_upstream_vld = 1'b0;
    sb(1'b1, bt(21));
    #1;
    tw = wd(6);
    chk("mrst_slice0", ubeat, tw[41:0]);
    chk("mrst_no_word", g.txfifo_downstream_vld, 0);
    step;
    sb(1'b0, '0);
    #1;
    chk("mrst_word", g.txfifo_downstream_data, {bt(21), bt(20)});
    step;
    step;
    #1;
    chk("mrst_idle", g.ustrm_beat_vld | g.txfifo_downstream_vld, 0);
    // lone low half followed by idle
    g.txfifo_downstream_rdy = 1'b0;
    sb(1'b1, bt(30));
    step;
    sb(1'b0, '0);
`ifdef LPIF_GEARBOX_PAD_EN
    for (int i = 1; i <= 4; i++) begin
      step;
      #1;
      chk($sformatf("pad_vld%0d", i), g.txfifo_downstream_vld, i == 4);
    end
    chk("pad_word", g.txfifo_downstream_data, {42'b0, bt(30)});
    g.txfifo_downstream_rdy = 1'b1;
    step;
    #1;
    chk("pad_drained", g.txfifo_downstream_vld, 0);
`else
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step;
      if (g.txfifo_downstream_vld) seen++;
    end
    chk("nopad_idle", seen, 0);
    g.txfifo_downstream_rdy = 1'b1;
    sb(1'b1, bt(31));
    step;
    sb(1'b0, '0);
    #1;
    chk("nopad_vld", g.txfifo_downstream_vld, 1);
    chk("nopad_word", g.txfifo_downstream_data, {bt(31), bt(30)});
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
